// File: rtl/mux_pkg.sv
// Shared select encoding and per-bit selection helper for the registered
// two-input data selector.
package mux_pkg;

    // One-bit select: 0 picks source A, 1 picks source B.
    typedef logic mux_sel_t;

    localparam mux_sel_t SEL_A = 1'b0;
    localparam mux_sel_t SEL_B = 1'b1;

    // Width limits accepted by the selector.
    localparam int MUX_MIN_WIDTH = 1;
    localparam int MUX_MAX_WIDTH = 64;

    // Single-bit 2:1 select; callers apply it across every bit with one
    // shared select so all bits always come from the same source.
    function automatic logic mux_select(input logic a, input logic b, input mux_sel_t sel);
        return (sel == SEL_B) ? b : a;
    endfunction

endpackage

// File: rtl/mux_2to1_sync.sv
// Registered two-input WIDTH-bit data selector with one pipeline stage.
// The select, the selected data and a valid qualifier are captured together
// so every output comes straight from a flop.
module mux_2to1_sync
    import mux_pkg::*;
#(
    parameter int         WIDTH       = 1,
    parameter logic [63:0] RESET_VALUE = 64'd0
) (
    input  logic             clk_in,
    input  logic             rst_n_in,
    input  logic [WIDTH-1:0] a_in,
    input  logic [WIDTH-1:0] b_in,
    input  logic             sel_in,
    input  logic             valid_in,
    output logic [WIDTH-1:0] y_out,
    output logic             valid_out,
    output logic             sel_q_out
);

    // Elaboration-time parameter sanity.
    if (WIDTH < MUX_MIN_WIDTH || WIDTH > MUX_MAX_WIDTH) begin : g_bad_width
        $error("mux_2to1_sync: WIDTH=%0d outside 1..64", WIDTH);
    end
    if (WIDTH < MUX_MAX_WIDTH && (RESET_VALUE >> WIDTH) != 64'd0) begin : g_bad_reset
        $error("mux_2to1_sync: RESET_VALUE does not fit in WIDTH=%0d bits", WIDTH);
    end

    // Stage 0: combinational select of the unregistered inputs.
    logic [WIDTH-1:0] y_p0;

    // Apply the same select to every bit of the two sources.
    always_comb begin
        y_p0 = '0;
        for (int i = 0; i < WIDTH; i++) begin
            y_p0[i] = mux_select(a_in[i], b_in[i], mux_sel_t'(sel_in));
        end
    end

    // Stage 1: registered outputs.
    logic [WIDTH-1:0] y_p1;
    mux_sel_t         sel_p1;
    logic             vld_p1;

    // Capture data and select on valid cycles; valid itself is copied every cycle.
    always_ff @(posedge clk_in or negedge rst_n_in) begin
        if (!rst_n_in) begin
            y_p1   <= RESET_VALUE[WIDTH-1:0];
            sel_p1 <= SEL_A;
            vld_p1 <= 1'b0;
        end else begin
            vld_p1 <= valid_in;
            if (valid_in) begin
                y_p1   <= y_p0;
                sel_p1 <= mux_sel_t'(sel_in);
            end
        end
    end

    assign y_out     = y_p1;
    assign sel_q_out = sel_p1;
    assign valid_out = vld_p1;

endmodule

// File: tb/tb_mux_2to1_sync.sv
// Directed scoreboard bench for mux_2to1_sync at WIDTH=8.
module tb_mux_2to1_sync;

    localparam int W = 8;

    logic         clk = 1'b0;
    logic         rst_n;
    logic [W-1:0] a, b, y;
    logic         sel, vld, vld_o, sel_q;

    mux_2to1_sync #(.WIDTH(W), .RESET_VALUE(64'd0)) dut (
        .clk_in    (clk),
        .rst_n_in  (rst_n),
        .a_in      (a),
        .b_in      (b),
        .sel_in    (sel),
        .valid_in  (vld),
        .y_out     (y),
        .valid_out (vld_o),
        .sel_q_out (sel_q)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [W-1:0] y;
        logic         v;
        logic         s;
    } exp_t;

    exp_t exp_q[$];

    // Reference model state
    logic [W-1:0] m_y;
    logic         m_s;
    logic         m_v;

    int pass_cnt = 0;
    int total    = 0;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] expv);
        total++;
        assert (obs === expv) pass_cnt++;
        else $error("FAIL %s observed=%0h expected=%0h", tag, obs, expv);
    endtask

    task automatic check_reset(input string tag);
        check({tag, "_y"}, 64'(y), 64'd0);
        check({tag, "_v"}, 64'(vld_o), 64'd0);
        check({tag, "_s"}, 64'(sel_q), 64'd0);
    endtask

    // Drive one cycle of stimulus at the falling edge, predict, then compare
    // just after the next rising edge.
    task automatic step(input string tag, input logic [W-1:0] ai, input logic [W-1:0] bi,
                        input logic si, input logic vi);
        exp_t e;
        @(negedge clk);
        a = ai; b = bi; sel = si; vld = vi;
        if (vi) begin
            m_y = si ? bi : ai;
            m_s = si;
        end
        m_v = vi;
        e.y = m_y; e.v = m_v; e.s = m_s;
        exp_q.push_back(e);
        @(posedge clk);
        #1;
        if (exp_q.size() == 0) begin
            total++;
            $error("FAIL %s scoreboard_empty observed=0 expected=1", tag);
        end else begin
            e = exp_q.pop_front();
            check({tag, "_y"}, 64'(y), 64'(e.y));
            check({tag, "_v"}, 64'(vld_o), 64'(e.v));
            check({tag, "_s"}, 64'(sel_q), 64'(e.s));
        end
    endtask

    initial begin
        // Reset held with all inputs high: outputs forced without any edge.
        rst_n = 1'b0; a = 8'h01; b = 8'h01; sel = 1'b1; vld = 1'b1;
        m_y = '0; m_s = 1'b0; m_v = 1'b0;
        #1;
        check_reset("rst_async");
        for (int i = 0; i < 3; i++) begin
            @(posedge clk); #1;
            check_reset("rst_hold");
        end
        @(negedge clk);
        rst_n = 1'b1;

        // Select A; b toggling must not matter.
        step("selA0", 8'h00, 8'h00, 1'b0, 1'b1);
        step("selA1", 8'h01, 8'h00, 1'b0, 1'b1);
        step("selA2", 8'h01, 8'h01, 1'b0, 1'b1);
        step("selA3", 8'h01, 8'h00, 1'b0, 1'b1);

        // Select B tracking a toggling b.
        step("selB0", 8'h00, 8'h01, 1'b1, 1'b1);
        step("selB1", 8'h00, 8'h00, 1'b1, 1'b1);
        step("selB2", 8'h00, 8'h01, 1'b1, 1'b1);
        step("selB3", 8'h00, 8'h00, 1'b1, 1'b1);

        // Alternating select every cycle.
        step("alt0", 8'hA5, 8'h3C, 1'b0, 1'b1);
        step("alt1", 8'hA5, 8'h3C, 1'b1, 1'b1);
        step("alt2", 8'hA5, 8'h3C, 1'b0, 1'b1);
        step("alt3", 8'hA5, 8'h3C, 1'b1, 1'b1);

        // Valid gating: inputs change while valid is low, output holds.
        step("gate0", 8'hFF, 8'h00, 1'b0, 1'b0);
        step("gate1", 8'h12, 8'h34, 1'b0, 1'b0);
        step("gate2", 8'h12, 8'h34, 1'b0, 1'b1);

        // Equal sources: select does not matter.
        step("eq0", 8'h5A, 8'h5A, 1'b1, 1'b1);
        step("eq1", 8'hC3, 8'hC3, 1'b0, 1'b1);

        // Full-width boundary values.
        step("wide0", 8'hFF, 8'h00, 1'b0, 1'b1);
        step("wide1", 8'hFF, 8'h00, 1'b1, 1'b1);

        // Reset mid-stream while y = 3C.
        step("mid0", 8'hA5, 8'h3C, 1'b1, 1'b1);
        #2;
        rst_n = 1'b0;
        #1;
        check_reset("mid_rst");
        m_y = '0; m_s = 1'b0; m_v = 1'b0;
        @(posedge clk); #1;
        check_reset("mid_hold");
        @(negedge clk);
        rst_n = 1'b1;
        step("post0", 8'hA5, 8'h3C, 1'b0, 1'b1);
        step("post1", 8'hA5, 8'h3C, 1'b1, 1'b1);

        total++;
        assert (exp_q.size() == 0) pass_cnt++;
        else $error("FAIL sb_drain observed=%0d expected=0", exp_q.size());

        $display("%0d/%0d checks passed", pass_cnt, total);
        $finish;
    end

endmodule
